// File: rtl/fractional_baud_generator.sv
// Fractional baud-rate generator: oversample tick plus bit tick.
// Define BAUD_FRAC_EN to compile the fractional phase accumulator.
module fractional_baud_generator #(
    parameter int N           = 16,
    parameter int F           = 4,
    parameter int OVS         = 16,
    parameter int DEFAULT_DIV = 651
) (
    input  logic         clk_100MHz,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         div_wr,
    input  logic [N-1:0] div_int,
    input  logic [F-1:0] div_frac,
    input  logic         sync,
    output logic         tick,
    output logic         bit_tick
);
    localparam int OW = $clog2(OVS);
    localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);
    localparam logic [OW-1:0] OVS_HALF = OW'(OVS / 2);

    logic [N-1:0]  div_int_q, div_int_d;
    logic [N-1:0]  cnt_q, cnt_d;
    logic [OW-1:0] ovs_q, ovs_d;
    logic          tick_q, tick_d;
    logic          bit_tick_q, bit_tick_d;
    logic [N-1:0]  div_eff;
    logic          carry;
    logic          term;

    // A carried period is one clock longer, so it ends one count later.
    assign div_eff = (div_int_q == '0) ? N'(1) : div_int_q;
    assign term    = carry ? (cnt_q == div_eff)
                           : (cnt_q == div_eff - N'(1));

    always_comb begin
        div_int_d  = div_int_q;
        cnt_d      = cnt_q;
        ovs_d      = ovs_q;
        tick_d     = 1'b0;
        bit_tick_d = 1'b0;
        if (div_wr) begin
            div_int_d = div_int;
            cnt_d     = '0;
            ovs_d     = '0;
        end else if (sync) begin
            cnt_d = '0;
            ovs_d = OVS_HALF;
        end else if (enable) begin
            if (term) begin
                cnt_d      = '0;
                tick_d     = 1'b1;
                bit_tick_d = (ovs_q == OVS_LAST);
                ovs_d      = ovs_q + OW'(1);
            end else begin
                cnt_d = cnt_q + N'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_int_q  <= N'(DEFAULT_DIV);
            cnt_q      <= '0;
            ovs_q      <= '0;
            tick_q     <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            div_int_q  <= div_int_d;
            cnt_q      <= cnt_d;
            ovs_q      <= ovs_d;
            tick_q     <= tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

`ifdef BAUD_FRAC_EN
    logic [F-1:0] div_frac_q, div_frac_d;
    logic [F-1:0] acc_q, acc_d;
    logic         carry_q, carry_d;

    assign carry = carry_q;

    always_comb begin
        div_frac_d = div_frac_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        if (div_wr) begin
            div_frac_d = div_frac;
            acc_d      = '0;
            carry_d    = 1'b0;
        end else if (sync) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (enable && term) begin
            {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, div_frac_q};
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_frac_q <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
        end else begin
            div_frac_q <= div_frac_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
        end
    end
`else
    // Integer-only divide: the fractional input has no effect.
    logic unused_frac;
    assign unused_frac = ^div_frac;
    assign carry       = 1'b0;
`endif

    assign tick     = tick_q;
    assign bit_tick = bit_tick_q;

endmodule

// File: doc/fractional_baud_generator.md
FRACTIONAL_BAUD_GENERATOR -- requirements
Module: fractional_baud_generator

Interface
REQ-001 SHALL have parameter N, default 16: width of integer divisor and tick counter.
REQ-002 SHALL have parameter F, default 4: width of fractional divisor and phase accumulator.
REQ-003 SHALL have parameter OVS, default 16: oversample ticks per bit, power of two, at least 2.
REQ-004 SHALL have parameter DEFAULT_DIV, default 651: integer divisor after reset (9600 baud x16 at 100 MHz).
REQ-005 SHALL have port clk_100MHz  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  input  1  count enable; low freezes the generator.
REQ-008 SHALL have port div_wr  input  1  single-cycle strobe loading div_int and div_frac.
REQ-009 SHALL have port div_int  input  N  integer part of the clocks-per-tick divisor.
REQ-010 SHALL have port div_frac  input  F  fractional part, in units of 1/2^F clock.
REQ-011 SHALL have port sync  input  1  single-cycle phase-realign strobe (RX start-bit edge).
REQ-012 SHALL have port tick  output  1  oversample tick, registered, one cycle wide.
REQ-013 SHALL have port bit_tick  output  1  bit tick, registered, coincident with every OVS-th tick.

Function
REQ-014 SHALL hold internal div_int_r, div_frac_r, tick counter cnt (N bits), accumulator acc (F bits), ovs_cnt (log2 OVS bits).
REQ-015 SHALL define the current period limit L = max(div_int_r,1) + carry, carry being the registered accumulator overflow from the previous terminal.
REQ-016 SHALL, when enable is high, increment cnt each cycle and at cnt == L-1 (terminal) clear cnt and assert tick on the next cycle.
REQ-017 SHALL, at each terminal, update acc <= (acc + div_frac_r) mod 2^F and register carry = overflow of that sum.
REQ-018 SHALL, at each terminal, increment ovs_cnt modulo OVS; bit_tick SHALL assert with the tick that follows a terminal where ovs_cnt was OVS-1.
REQ-019 SHALL treat div_int_r == 0 as 1; period 1 with carry 0 asserts tick every cycle.
REQ-020 SHALL, on div_wr, load div_int_r and div_frac_r and clear cnt, acc, carry and ovs_cnt; no tick or bit_tick in the following cycle.
REQ-021 SHALL, on sync without div_wr, clear cnt, acc and carry and set ovs_cnt to OVS/2; first bit_tick then follows after OVS/2 ticks.
REQ-022 SHALL apply priority div_wr > sync > counting in the same cycle.
REQ-023 SHALL honour div_wr and sync regardless of enable.
REQ-024 SHALL, when enable is low, hold cnt, acc, carry and ovs_cnt and drive tick and bit_tick low the next cycle.
REQ-025 SHALL take the first tick exactly L cycles after div_wr, sync or reset release with enable high.

Reset
REQ-026 SHALL, on reset_n low, immediately set cnt=0, acc=0, carry=0, ovs_cnt=0, tick=0, bit_tick=0, div_int_r=DEFAULT_DIV, div_frac_r=0.
REQ-027 SHALL, on reset mid-period, discard the partial period; counting restarts from cnt=0 on the first edge after release.

Configuration
REQ-028 SHALL compile the fractional accumulator only when macro BAUD_FRAC_EN is defined.
REQ-029 SHALL, with BAUD_FRAC_EN defined, behave per REQ-015..REQ-017 (average period div_int + div_frac/2^F).
REQ-030 SHALL, without BAUD_FRAC_EN, omit acc and carry, ignore div_frac and fix carry at 0 (pure integer divide).

Verification
REQ-031 SHALL cover reset release, enable=1, defaults -> tick every 651 cycles, bit_tick every 10416 cycles (16 ticks).
REQ-032 SHALL cover div_wr div_int=4, div_frac=8 (F=4), BAUD_FRAC_EN -> tick periods 4,4,5,4,5,4; without macro -> 4,4,4,4.
REQ-033 SHALL cover div_int=3, OVS=16, sync mid-bit -> next bit_tick exactly 8 ticks (24 cycles) after sync; the next after 16 ticks.
REQ-034 SHALL cover div_wr and sync in the same cycle -> new divisor loaded, ovs_cnt=0, first bit_tick after 16 ticks.
REQ-035 SHALL cover enable low for 10 cycles mid-period at div_int=5 -> no ticks; period resumes and completes 5 counted cycles total.
REQ-036 SHALL cover reset_n asserted mid-period -> tick/bit_tick low at once; first tick 651 cycles after release.
